// File: rtl/vec_relu_seq_if.sv
// Handshake bundle for vec_relu_seq: input vector channel, result channel and busy flag.
interface vec_relu_seq_if #(
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_vec;
  logic              busy;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec, busy
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec, busy
  );
endinterface

// File: rtl/vec_relu_seq.sv
// Vector ReLU over packed floating-point elements, time-sharing LANES ReLU units
// across the vector one chunk per cycle, with a valid/ready handshake on both sides.
module vec_relu_seq #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int VEC_SIZE   = 4,
  parameter int LANES      = 1
) (
  input  logic           clk,
  input  logic           rst,
  vec_relu_seq_if.slave  bus
);
  localparam int W       = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int VW      = VEC_SIZE * W;
  localparam int N       = VEC_SIZE / LANES;
  localparam int CW      = (N > 1) ? $clog2(N) : 1;
  localparam int CHUNK_W = LANES * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CW-1:0]      cnt_r;
  logic [VW-1:0]      op_r;
  logic [VW-1:0]      res_r;
  logic [CHUNK_W-1:0] chunk_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               last_s;

  // Negative sign (including -0 and negative NaN) collapses to +0.
  function automatic logic [W-1:0] relu(input logic [W-1:0] e);
    if (e[W-1]) begin
      relu = {W{1'b0}};
    end else begin
      relu = e;
    end
  endfunction

  // ReLU of the chunk currently selected by the counter.
  always_comb begin
    chunk_s = {CHUNK_W{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      chunk_s[l*W +: W] = relu(op_r[(int'(cnt_r) * LANES + l) * W +: W]);
    end
  end

  // In DONE the slot frees up in the same cycle the result is taken.
  always_comb begin
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      DONE:    in_ready_s = bus.out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign accept_s = bus.in_valid && in_ready_s;
  assign last_s   = (cnt_r == CW'(N - 1));

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = bus.in_valid ? RUN : IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, chunk counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= {VW{1'b0}};
      res_r <= {VW{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      op_r  <= bus.in_vec;
      cnt_r <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      res_r[int'(cnt_r) * CHUNK_W +: CHUNK_W] <= chunk_s;
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == DONE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.out_vec   = res_r;
endmodule

// File: tb/tb_vec_relu_seq.sv
// Scoreboard bench for vec_relu_seq: LANES=1 instance for function, handshake and reset,
// LANES=2 instance for the shortened latency.
module tb_vec_relu_seq;
  localparam int VW = 128;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  int   acc_edge;
  logic ov_prev;
  logic [VW-1:0] exp_q[$];

  vec_relu_seq_if #(.DATA_W(VW)) bus1 ();
  vec_relu_seq_if #(.DATA_W(VW)) bus2 ();

  vec_relu_seq #(.EXP_WIDTH(8), .MANT_WIDTH(23), .VEC_SIZE(4), .LANES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  vec_relu_seq #(.EXP_WIDTH(8), .MANT_WIDTH(23), .VEC_SIZE(4), .LANES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] relu_model(input logic [VW-1:0] v);
    logic [31:0] e;
    relu_model = {VW{1'b0}};
    for (int i = 0; i < 4; i++) begin
      e = v[i*32 +: 32];
      relu_model[i*32 +: 32] = e[31] ? 32'h0000_0000 : e;
    end
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    rand_vec = {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard monitor for the LANES=1 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_edge <= -1;
      ov_prev  <= 1'b0;
    end else begin
      if (bus1.out_valid) begin
        check_eq("valid_has_exp", VW'(exp_q.size() > 0), 1);
      end
      if (bus1.out_valid && !ov_prev && acc_edge >= 0) begin
        check_eq("latency_l1", VW'(cyc - acc_edge), 4);
      end
      if (bus1.out_valid && bus1.out_ready && exp_q.size() > 0) begin
        check_eq("out_vec", bus1.out_vec, exp_q.pop_front());
      end
      if (bus1.in_valid && bus1.in_ready) begin
        exp_q.push_back(relu_model(bus1.in_vec));
        acc_edge <= cyc + 1;
      end
      ov_prev <= bus1.out_valid;
    end
  end

  task automatic send1(input logic [VW-1:0] v, output int edge_no);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_vec   = v;
    while (!got && n < 40) begin
      @(negedge clk);
      got = bus1.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    edge_no = cyc;
    if (!got) check_eq("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || bus1.out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", VW'(exp_q.size()), 0);
  endtask

  logic [VW-1:0] v1;
  logic [VW-1:0] v1_exp;
  logic [VW-1:0] v3;
  logic [VW-1:0] v3_exp;
  logic [VW-1:0] vb;
  int            e0;
  int            e1;
  int            e2;
  int            n;

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    v1     = {32'h7FC0_0000, 32'h8000_0000, 32'hBF80_0000, 32'h3F80_0000};
    v1_exp = {32'h7FC0_0000, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000};
    v3     = {32'hFFC0_0000, 32'h7F80_0000, 32'h0000_0001, 32'hFF80_0000};
    v3_exp = {32'h0000_0000, 32'h7F80_0000, 32'h0000_0001, 32'h0000_0000};
    vb     = {4{32'hC000_0000}};
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_vec = '0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_vec = '0; bus2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", VW'(bus1.in_ready), 1);
    check_eq("rst_out_valid", VW'(bus1.out_valid), 0);
    check_eq("rst_busy", VW'(bus1.busy), 0);
    check_eq("rst_out_vec", bus1.out_vec, 0);
    rst = 1'b0;

    // Basic vector through LANES=1.
    bus1.out_ready = 1'b1;
    send1(v1, e0);
    bus1.in_valid = 1'b0;
    wait_drain();

    // Backpressure: result held 5 cycles while in_vec churns.
    bus1.out_ready = 1'b0;
    send1(v3, e0);
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_out_valid", VW'(bus1.out_valid), 1);
      check_eq("bp_out_vec", bus1.out_vec, v3_exp);
      check_eq("bp_in_ready", VW'(bus1.in_ready), 0);
      bus1.in_valid = 1'b1;
      bus1.in_vec   = rand_vec();
      @(posedge clk);
      #1;
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    wait_drain();

    // Back-to-back with in_valid held high: one vector per 5 cycles.
    send1(v1, e0);
    send1(vb, e1);
    send1(rand_vec(), e2);
    bus1.in_valid = 1'b0;
    check_eq("b2b_gap_ab", VW'(e1 - e0), 5);
    check_eq("b2b_gap_bc", VW'(e2 - e1), 5);
    wait_drain();

    // Random vectors.
    for (int i = 0; i < 6; i++) begin
      send1(rand_vec(), e0);
      bus1.in_valid = 1'b0;
      wait_drain();
    end

    // Reset after two chunks; in_valid during reset must be ignored.
    send1(v1, e0);
    bus1.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.in_vec   = v3;
    @(posedge clk);
    #1;
    check_eq("mid_rst_out_valid", VW'(bus1.out_valid), 0);
    check_eq("mid_rst_in_ready", VW'(bus1.in_ready), 1);
    check_eq("mid_rst_busy", VW'(bus1.busy), 0);
    check_eq("mid_rst_out_vec", bus1.out_vec, 0);
    rst = 1'b0;
    bus1.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("post_rst_idle", VW'(bus1.busy), 0);

    // LANES=2: two-cycle latency, busy across RUN and DONE.
    bus2.in_valid  = 1'b1;
    bus2.in_vec    = v1;
    bus2.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    bus2.in_vec   = rand_vec();
    check_eq("l2_run0_busy", VW'(bus2.busy), 1);
    check_eq("l2_run0_valid", VW'(bus2.out_valid), 0);
    @(posedge clk);
    #1;
    check_eq("l2_run1_busy", VW'(bus2.busy), 1);
    check_eq("l2_run1_valid", VW'(bus2.out_valid), 0);
    @(posedge clk);
    #1;
    check_eq("l2_done_valid", VW'(bus2.out_valid), 1);
    check_eq("l2_done_busy", VW'(bus2.busy), 1);
    check_eq("l2_done_vec", bus2.out_vec, v1_exp);
    check_eq("l2_done_in_ready", VW'(bus2.in_ready), 0);
    bus2.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("l2_idle_valid", VW'(bus2.out_valid), 0);
    check_eq("l2_idle_busy", VW'(bus2.busy), 0);
    check_eq("l2_idle_in_ready", VW'(bus2.in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_relu_seq.md
VEC_RELU_SEQ -- requirements
Module: vec_relu_seq

Interface
REQ-001 The block SHALL have parameter EXP_WIDTH, default 8, exponent bits per element.
REQ-002 The block SHALL have parameter MANT_WIDTH, default 23, mantissa bits per element; element width W = 1+EXP_WIDTH+MANT_WIDTH, sign at bit W-1.
REQ-003 The block SHALL have parameter VEC_SIZE, default 4, elements per vector; element i occupies bits [i*W+W-1 : i*W].
REQ-004 The block SHALL have parameter LANES, default 1, ReLU units instantiated; VEC_SIZE SHALL be a multiple of LANES, N = VEC_SIZE/LANES.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit, input vector valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, block can accept a vector.
REQ-009 The block SHALL have port in_vec, input, VEC_SIZE*W bits, input vector.
REQ-010 The block SHALL have port out_valid, output, 1 bit, result vector valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-012 The block SHALL have port out_vec, output, VEC_SIZE*W bits, registered result vector.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-014 ReLU per element SHALL be: sign bit 1 -> all W bits zero; sign bit 0 -> element unchanged (-0 -> +0, negative NaN -> +0, positive NaN/+inf pass).
REQ-015 The block SHALL time-share LANES ReLU units across the vector, processing chunk k (elements k*LANES .. k*LANES+LANES-1) in one cycle.
REQ-016 The FSM SHALL have states IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL capture in_vec into an operand register, clear chunk counter to 0, go to RUN.
REQ-018 RUN: each edge SHALL write ReLU of chunk[counter] into the result register and increment counter; on the edge processing chunk N-1 the block SHALL go to DONE; in_ready=0.
REQ-019 DONE: out_valid=1, out_vec stable, SHALL hold until out_ready=1.
REQ-020 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-021 DONE with out_ready=1 and in_valid=1 SHALL accept the new vector in the same cycle (in_ready=out_ready while in DONE) and go directly to RUN, counter 0.
REQ-022 Latency: out_valid SHALL rise exactly N cycles after the accepting edge; sustained throughput one vector per N+1 cycles.
REQ-023 in_vec changes while in RUN or DONE SHALL not affect the result in flight.
REQ-024 Result elements of chunks not yet processed SHALL retain prior values; out_vec is only defined while out_valid=1.
REQ-025 Counter width SHALL be clog2(N), min 1; with N=1, RUN lasts one cycle.
REQ-026 out_valid SHALL never assert in IDLE or RUN; in_valid/out_ready held low SHALL cause no state change outside RUN.

Reset
REQ-027 rst=1 at a rising edge SHALL force state IDLE, counter 0, result and operand registers 0, out_valid=0, busy=0, in_ready=1 after that edge.
REQ-028 rst SHALL take priority over all handshakes; a vector in RUN or DONE at reset SHALL be discarded with no out_valid pulse.
REQ-029 An in_valid asserted during the rst cycle SHALL not be accepted.

Verification (EXP_WIDTH=8, MANT_WIDTH=23, VEC_SIZE=4)
REQ-030 LANES=1, in_vec elements {0x3F800000, 0xBF800000, 0x80000000, 0x7FC00000} accepted -> out_valid exactly 4 cycles later, out_vec {0x3F800000, 0x00000000, 0x00000000, 0x7FC00000}.
REQ-031 LANES=2, same input -> out_valid exactly 2 cycles after acceptance, same out_vec; busy high for the RUN and DONE cycles.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_vec held stable, in_ready=0, in_vec toggled meanwhile has no effect.
REQ-033 Back-to-back: in_valid=1 continuously, out_ready=1, vectors A then B {0xC0000000 x4} -> B accepted on the cycle A is consumed, B result all zeros; one vector per 5 cycles with LANES=1.
REQ-034 Reset mid-RUN after 2 chunks -> next cycle state IDLE, out_valid=0, in_ready=1, out_vec 0; no stale result ever emitted.
